// File: rtl/anim_pkg.sv
// Shared definitions for the layer sequencer: wrap/boundary defaults, FSM states, sprite index type.
package anim_pkg;

  localparam int unsigned H_WRAP_DEFAULT       = 320;
  localparam int unsigned V_WRAP_DEFAULT       = 240;
  localparam int unsigned V_BLANK_LINE_DEFAULT = 480;
  localparam int unsigned FRAME_DIV_DEFAULT    = 4;
  localparam int unsigned IDX_W                = 4;

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    DONE
  } anim_state_t;

endpackage

// File: rtl/anim_scroll_ctrl_wrap_step.sv
// Combinational modular add/sub of a scroll offset by a small step; offset assumed < MODULUS.
module wrap_step #(
  parameter int unsigned MODULUS = 320
) (
  input  logic [9:0] offset,
  input  logic [3:0] step,
  input  logic       inc,
  input  logic       dec,
  output logic [9:0] result
);

  localparam logic [10:0] MOD = 11'(MODULUS);

  logic [10:0] sum;
  logic [10:0] diff;

  always_comb begin
    sum    = {1'b0, offset} + {7'd0, step};
    diff   = {1'b0, offset} - {7'd0, step};
    result = offset;
    if (inc && !dec) begin
      result = (sum >= MOD) ? 10'(sum - MOD) : sum[9:0];
    end else if (dec && !inc) begin
      // underflow wraps mod 2^11 first; adding MOD restores the true residue
      result = (offset < {6'd0, step}) ? 10'(diff + MOD) : diff[9:0];
    end
  end

endmodule

// File: rtl/anim_scroll_ctrl.sv
// Per-frame scroll/animation sequencer for one layer; all updates commit on the clk after frame_tick.
// Optional ANIM_PINGPONG_EN: loop mode bounces first..last..first instead of wrapping.
module anim_scroll_ctrl
  import anim_pkg::*;
#(
  parameter int unsigned H_WRAP       = H_WRAP_DEFAULT,
  parameter int unsigned V_WRAP       = V_WRAP_DEFAULT,
  parameter int unsigned V_BLANK_LINE = V_BLANK_LINE_DEFAULT,
  parameter int unsigned FRAME_DIV    = FRAME_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] h_cnt,
  input  logic [9:0] v_cnt,
  input  logic       mv_left,
  input  logic       mv_right,
  input  logic       mv_up,
  input  logic       mv_down,
  input  logic [3:0] step_h,
  input  logic [3:0] step_v,
  input  logic       anim_en,
  input  logic       anim_loop,
  input  logic [3:0] anim_first,
  input  logic [3:0] anim_last,
  output logic [9:0] pos_h,
  output logic [9:0] pos_v,
  output logic [3:0] now_pixel_idx,
  output logic       frame_tick,
  output logic       anim_done
);

  localparam logic [7:0] DIV_LAST = 8'(FRAME_DIV - 1);

  anim_state_t state_q, state_d;
  logic [7:0]  div_q, div_d;
  idx_t        idx_q, idx_d, eff_first;
  logic        single, done_d;
  logic        cond, cond_q, armed;
  logic [9:0]  pos_h_nx, pos_v_nx;
`ifdef ANIM_PINGPONG_EN
  logic        dir_q, dir_d;
`endif

  assign cond          = (v_cnt == 10'(V_BLANK_LINE)) && (h_cnt == '0);
  assign now_pixel_idx = idx_q;
  assign eff_first     = (anim_first == '0) ? idx_t'(1) : anim_first;
  assign single        = anim_last < eff_first;

  // armed blocks a tick until cond has been seen low, so a reset inside the boundary needs a fresh edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cond_q     <= 1'b0;
      armed      <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      cond_q     <= cond;
      armed      <= armed | ~cond;
      frame_tick <= cond & ~cond_q & armed;
    end
  end

  wrap_step #(.MODULUS(H_WRAP)) u_wrap_h (
    .offset(pos_h), .step(step_h), .inc(mv_right), .dec(mv_left), .result(pos_h_nx)
  );

  wrap_step #(.MODULUS(V_WRAP)) u_wrap_v (
    .offset(pos_v), .step(step_v), .inc(mv_down), .dec(mv_up), .result(pos_v_nx)
  );

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
`ifdef ANIM_PINGPONG_EN
    dir_d   = dir_q;
`endif
    if (frame_tick) begin
      case (state_q)
        IDLE: begin
          idx_d = eff_first;
          div_d = '0;
`ifdef ANIM_PINGPONG_EN
          dir_d = 1'b0;
`endif
          if (anim_en) state_d = PLAY;
        end
        PLAY: begin
          if (!anim_en) begin
            state_d = IDLE;
            idx_d   = eff_first;
            div_d   = '0;
`ifdef ANIM_PINGPONG_EN
            dir_d   = 1'b0;
`endif
          end else if (div_q != DIV_LAST) begin
            div_d = div_q + 8'd1;
          end else begin
            div_d = '0;
            if (single || idx_q < eff_first || idx_q > anim_last) begin
              idx_d = eff_first;
`ifdef ANIM_PINGPONG_EN
              dir_d = 1'b0;
            end else if (anim_loop && dir_q) begin
              if (idx_q == eff_first) begin
                dir_d = 1'b0;
                if (idx_q != anim_last) idx_d = idx_q + idx_t'(1);
              end else begin
                idx_d = idx_q - idx_t'(1);
              end
`endif
            end else if (idx_q != anim_last) begin
              idx_d = idx_q + idx_t'(1);
            end else if (anim_loop) begin
`ifdef ANIM_PINGPONG_EN
              if (anim_last != eff_first) begin
                dir_d = 1'b1;
                idx_d = idx_q - idx_t'(1);
              end
`else
              idx_d = eff_first;
`endif
            end else begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end
        end
        DONE: begin
          if (!anim_en) begin
            state_d = IDLE;
            idx_d   = eff_first;
            div_d   = '0;
`ifdef ANIM_PINGPONG_EN
            dir_d   = 1'b0;
`endif
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      div_q     <= '0;
      idx_q     <= idx_t'(1);
      anim_done <= 1'b0;
      pos_h     <= '0;
      pos_v     <= '0;
`ifdef ANIM_PINGPONG_EN
      dir_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      idx_q     <= idx_d;
      anim_done <= done_d;
`ifdef ANIM_PINGPONG_EN
      dir_q     <= dir_d;
`endif
      if (frame_tick) begin
        pos_h <= pos_h_nx;
        pos_v <= pos_v_nx;
      end
    end
  end

endmodule

// File: doc/anim_scroll_ctrl.md
Name: anim_scroll_ctrl

Overview:
- Per-frame sequencer for one sprite/background layer.
- Generates the layer's scroll offsets (pos_h, pos_v, wrapped to 320x240) and its animation sprite index (now_pixel_idx) consumed by the pixel-select mux.
- Updates commit only at the start of vertical blanking, so the mux inputs stay stable across every visible frame.

Parameters:
- H_WRAP, 320: horizontal wrap modulus for pos_h.
- V_WRAP, 240: vertical wrap modulus for pos_v.
- V_BLANK_LINE, 480: v_cnt value that marks the frame boundary.
- FRAME_DIV, 4: frame ticks per animation step (1..255).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- h_cnt  in  10  VGA horizontal counter.
- v_cnt  in  10  VGA vertical counter.
- mv_left, mv_right, mv_up, mv_down  in  1 each  move requests, level, sampled at frame tick.
- step_h  in  4  horizontal pixels per frame.
- step_v  in  4  vertical pixels per frame.
- anim_en  in  1  animation run enable.
- anim_loop  in  1  1 = loop, 0 = one-shot.
- anim_first  in  4  first sprite index.
- anim_last  in  4  last sprite index.
- pos_h  out  10  horizontal scroll offset, 0..H_WRAP-1.
- pos_v  out  10  vertical scroll offset, 0..V_WRAP-1.
- now_pixel_idx  out  4  current sprite index.
- frame_tick  out  1  one-cycle pulse per frame.
- anim_done  out  1  one-cycle pulse when a one-shot animation ends.

Behaviour:
- Reset (async, rst_n=0): pos_h=0, pos_v=0, now_pixel_idx=4'h1, frame_tick=0, anim_done=0, state=IDLE, divider=0, boundary flag=0.
- Frame tick:
  - cond = (v_cnt==V_BLANK_LINE && h_cnt==0), registered every clk.
  - frame_tick pulses exactly one clk on the rising edge of cond, even though counters hold for several clk (pixel clock = clk/4).
  - All state updates below occur on the clk after frame_tick; outputs never change at any other time.
- Scroll, horizontal:
  - mv_right only: pos_h = pos_h+step_h, minus H_WRAP if result >= H_WRAP.
  - mv_left only: pos_h = pos_h-step_h, plus H_WRAP if result would go below 0.
  - Both asserted or neither: hold.
  - Arithmetic is 11-bit internally so no aliasing occurs. step 0 = hold.
- Scroll, vertical: same rules with mv_down (+) / mv_up (-) and V_WRAP.
- Effective first index: eff_first = (anim_first==0) ? 1 : anim_first, because index 0 aliases sprite 1. If anim_last < eff_first, the animation is a single frame: idx = eff_first.
- FSM:
  - IDLE: idx=eff_first, divider=0. Goes to PLAY on the tick where anim_en=1.
  - PLAY: each tick, divider increments. At divider==FRAME_DIV-1, divider clears and idx advances.
    - idx<anim_last: idx+1.
    - idx==anim_last, anim_loop=1: idx=eff_first.
    - idx==anim_last, anim_loop=0: go to DONE, anim_done pulses one clk, idx holds last.
  - DONE: holds. Goes to IDLE when anim_en=0 (sampled at tick).
  - anim_en=0 in PLAY: go to IDLE at next tick; idx returns to eff_first.
- anim_first/anim_last changing mid-PLAY: idx outside the new range jumps to eff_first at the next step.
- Reset mid-frame: immediate return to reset values. The next frame_tick requires a fresh rising edge of cond.

Optional Feature:
- Macro: ANIM_PINGPONG_EN.
- Defined: loop mode bounces. The direction bit flips at anim_last and at eff_first, so the sequence is first..last..first, with no repeated endpoint. Direction resets to up in IDLE/reset.
- Undefined: loop wraps last -> first. No direction register is synthesized.

Decomposition:
- Shared package anim_pkg: H_WRAP/V_WRAP/V_BLANK_LINE defaults, 3-state enum (IDLE, PLAY, DONE), sprite index width 4.
- One sub-module wrap_step: combinational modular add/sub of an offset by a step with a modulus parameter. Instantiated twice, for h and v.

Test Plan:
- Reset then 3 frames, no moves, anim_en=0 -> pos_h=pos_v=0, idx=1; frame_tick exactly 1 clk wide per frame despite 4-clk counter hold.
- mv_right, step_h=7, from pos_h=315 -> 2 next frame; mv_left, step_h=5, from 3 -> 318; mv_up, step_v=4, from 0 -> 236; mv_left+mv_right together -> pos_h unchanged.
- anim_en=1, loop, first=2, last=4, FRAME_DIV=2 -> idx 2,2,3,3,4,4,2,2 across 8 ticks; idx constant between ticks.
- One-shot, first=0, last=3, FRAME_DIV=1 -> idx 1,2,3, anim_done single pulse, idx holds 3; anim_en=0 -> idx back to 1.
- first=9, last=5 -> idx fixed 9. rst_n low mid-PLAY -> idx=1, pos 0, immediately, asynchronously.
- With ANIM_PINGPONG_EN, first=1, last=3, FRAME_DIV=1 -> idx 1,2,3,2,1,2,3.
